// File: rtl/pattern_checker.sv
// Receive-side monitor for the bouncing one-hot pattern.
// Acquires sequence phase from a repeated end value, then tracks it with a flywheel.
module pattern_checker #(
    parameter int MISS_LIMIT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [7:0]       pattern,
    output logic             locked,
    output logic [2:0]       position,
    output logic             direction,
    output logic [1:0]       cycle,
    output logic             match,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic             period_done
);

    localparam int MW = $clog2(MISS_LIMIT + 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       prev_q, prev_d;
    logic [7:0]       exp_q, exp_d;
    logic [1:0]       cyc_q, cyc_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [ERR_W-1:0] errc_q, errc_d;
    logic [2:0]       pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic             pd_q, pd_d;

    logic [7:0]       nxt_d;
    logic [1:0]       nxt_c;
    logic [MW-1:0]    miss_inc;
    logic [2:0]       idx;
    logic             one_hot;

    // Generator model: returns {next cycle, next value}.
    function automatic logic [9:0] next_fn(input logic [7:0] d, input logic [1:0] c);
        logic [7:0] nd;
        logic [1:0] nc;
        nd = d;
        nc = c;
        if (!c[1]) begin
            if (d[0]) begin
                nd = (c == 2'd1) ? 8'h01 : 8'h80;
                nc = c + 2'd1;
            end else begin
                nd = d >> 1;
            end
        end else begin
            if (d[7]) begin
                nd = (c == 2'd3) ? 8'h80 : 8'h01;
                nc = c + 2'd1;
            end else begin
                nd = d << 1;
            end
        end
        return {nc, nd};
    endfunction

    assign {nxt_c, nxt_d} = next_fn(exp_q, cyc_q);
    assign miss_inc = miss_q + 1'b1;
    assign one_hot = $onehot(pattern);

    // Bit index of the sample, meaningful only for one-hot values.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pattern[i]) idx = 3'(i);
        end
    end

    // Next-state and output logic for the HUNT/LOCKED tracker.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        exp_d   = exp_q;
        cyc_d   = cyc_q;
        miss_d  = miss_q;
        errc_d  = errc_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        match_d = 1'b0;
        err_d   = 1'b0;
        pd_d    = 1'b0;
        if (sample_valid) begin
            unique case (state_q)
                HUNT: begin
                    miss_d = '0;
                    if (pattern == prev_q && pattern == 8'h01) begin
                        state_d = LOCKED;
                        cyc_d   = 2'd2;
                        exp_d   = 8'h02;
                    end else if (pattern == prev_q && pattern == 8'h80) begin
                        state_d = LOCKED;
                        cyc_d   = 2'd0;
                        exp_d   = 8'h40;
                    end else begin
                        prev_d = pattern;
                    end
                    if (one_hot) begin
                        pos_d = idx;
                        dir_d = cyc_d[1];
                    end
                end
                LOCKED: begin
                    exp_d = nxt_d;
                    cyc_d = nxt_c;
                    if (pattern == exp_q) begin
                        match_d = 1'b1;
                        miss_d  = '0;
                        pos_d   = idx;
                        dir_d   = nxt_c[1];
                        pd_d    = (cyc_q == 2'd3) && (nxt_c == 2'd0);
                    end else begin
                        err_d = 1'b1;
                        if (errc_q != '1) errc_d = errc_q + 1'b1;
                        if (miss_inc == MW'(MISS_LIMIT)) begin
                            state_d = HUNT;
                            miss_d  = '0;
                            prev_d  = pattern;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; clear wins over any sample in the same cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= HUNT;
            prev_q  <= '0;
            exp_q   <= '0;
            cyc_q   <= '0;
            miss_q  <= '0;
            errc_q  <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
            pd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            exp_q   <= exp_d;
            cyc_q   <= cyc_d;
            miss_q  <= miss_d;
            errc_q  <= errc_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            match_q <= match_d;
            err_q   <= err_d;
            pd_q    <= pd_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign position    = pos_q;
    assign direction   = dir_q;
    assign cycle       = cyc_q;
    assign match       = match_q;
    assign error       = err_q;
    assign err_count   = errc_q;
    assign period_done = pd_q;

endmodule

// File: tb/tb_pattern_checker.sv
// Testbench for pattern_checker: vector table, corner sequences and
// randomized traffic against a period-index reference model.
module tb_pattern_checker;

    logic       clk;
    logic       clear;
    logic       sample_valid;
    logic [7:0] pattern;

    logic       locked, direction, match, error, period_done;
    logic [2:0] position;
    logic [1:0] cycle;
    logic [7:0] err_count;

    logic       locked2, direction2, match2, error2, period_done2;
    logic [2:0] position2;
    logic [1:0] cycle2;
    logic [1:0] err_count2;

    pattern_checker #(.MISS_LIMIT(2), .ERR_W(8)) dut (
        .clk(clk), .clear(clear), .sample_valid(sample_valid),
        .pattern(pattern), .locked(locked), .position(position),
        .direction(direction), .cycle(cycle), .match(match),
        .error(error), .err_count(err_count), .period_done(period_done)
    );

    pattern_checker #(.MISS_LIMIT(2), .ERR_W(2)) dut2 (
        .clk(clk), .clear(clear), .sample_valid(sample_valid),
        .pattern(pattern), .locked(locked2), .position(position2),
        .direction(direction2), .cycle(cycle2), .match(match2),
        .error(error2), .err_count(err_count2), .period_done(period_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] gen [32];

    // Reference model: phase is an index into the 32-entry period.
    logic m_locked;
    int   m_p;
    logic [7:0] m_prev;
    int   m_miss;
    int   m_ec;
    int   m_ec2;
    logic [2:0] m_pos;
    logic m_dir;
    logic [1:0] m_cyc;
    logic m_match, m_err, m_pd;

    task automatic model(input logic c, input logic v, input logic [7:0] p);
        if (c) begin
            m_locked = 0; m_p = 0; m_prev = 0; m_miss = 0;
            m_ec = 0; m_ec2 = 0; m_pos = 0; m_dir = 0; m_cyc = 0;
            m_match = 0; m_err = 0; m_pd = 0;
        end else begin
            m_match = 0; m_err = 0; m_pd = 0;
            if (v) begin
                if (!m_locked) begin
                    if (p == m_prev && p == 8'h80) begin
                        m_locked = 1; m_p = 1;
                    end else if (p == m_prev && p == 8'h01) begin
                        m_locked = 1; m_p = 17;
                    end else begin
                        m_prev = p;
                    end
                    m_miss = 0;
                    m_cyc = 2'(m_p / 8);
                    if ($countones(p) == 1) begin
                        m_pos = 3'($clog2(p));
                        m_dir = (m_p >= 16);
                    end
                end else begin
                    int np;
                    np = (m_p + 1) % 32;
                    if (p == gen[m_p]) begin
                        m_match = 1;
                        m_pd = (m_p == 31);
                        m_miss = 0;
                        m_pos = 3'($clog2(p));
                        m_dir = (np >= 16);
                    end else begin
                        m_err = 1;
                        if (m_ec < 255) m_ec++;
                        if (m_ec2 < 3) m_ec2++;
                        m_miss++;
                        if (m_miss == 2) begin
                            m_locked = 0; m_miss = 0; m_prev = p;
                        end
                    end
                    m_p = np;
                    m_cyc = 2'(m_p / 8);
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [7:0] p);
        clear = c;
        sample_valid = v;
        pattern = p;
        @(posedge clk);
        #1;
        model(c, v, p);
        chk("model_main",
            {14'd0, locked, position, direction, cycle, match, error, err_count, period_done},
            {14'd0, m_locked, m_pos, m_dir, m_cyc, m_match, m_err, 8'(m_ec), m_pd});
        chk("model_ew2",
            {20'd0, locked2, position2, direction2, cycle2, match2, error2, err_count2, period_done2},
            {20'd0, m_locked, m_pos, m_dir, m_cyc, m_match, m_err, 2'(m_ec2), m_pd});
    endtask

    typedef struct {
        logic       clr;
        logic       vld;
        logic [7:0] pat;
        logic       lk;
        logic [1:0] cyc;
        logic       m;
        logic       e;
        logic       pd;
        logic [7:0] ec;
        logic [2:0] pos;
        logic       dir;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int mcnt, pcnt, chg, badchg;
        logic [1:0] lastc;
        int gp;

        for (int i = 0; i < 32; i++) begin
            if (i < 16) gen[i] = 8'h80 >> (i % 8);
            else gen[i] = 8'h01 << (i % 8);
        end

        tbl[0]  = '{1'b1, 1'b1, 8'h80, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h80, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h80, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd7, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h80, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd7, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h40, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd6, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd6, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h20, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd5, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd1, 3'd5, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h08, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd3, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd2, 3'd3, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 8'd3, 3'd3, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd3, 3'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h01, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'd3, 3'd0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'h02, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd3, 3'd1, 1'b1};

        clear = 1'b1;
        sample_valid = 1'b0;
        pattern = 8'h00;

        // Reset then idle
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'($urandom));
            chk("idle_zero",
                {14'd0, locked, position, direction, cycle, match, error, err_count, period_done},
                32'd0);
        end

        // Vector table
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].clr, tbl[i].vld, tbl[i].pat);
            chk($sformatf("tbl%0d", i),
                {14'd0, locked, cycle, match, error, period_done, err_count, position, direction},
                {14'd0, tbl[i].lk, tbl[i].cyc, tbl[i].m, tbl[i].e, tbl[i].pd,
                 tbl[i].ec, tbl[i].pos, tbl[i].dir});
        end

        // Full period: 64 samples after acquiring on 0x80,0x80
        step(1, 0, 8'h00);
        step(0, 1, 8'h80);
        step(0, 1, 8'h80);
        chk("acq80", {locked, cycle, direction}, {1'b1, 2'd0, 1'b0});
        mcnt = 0; pcnt = 0; chg = 0; badchg = 0;
        lastc = cycle;
        for (int i = 0; i < 64; i++) begin
            step(0, 1, gen[(1 + i) % 32]);
            if (match) mcnt++;
            if (period_done) pcnt++;
            if (cycle != lastc) begin
                chg++;
                if (cycle != lastc + 2'd1) badchg++;
                lastc = cycle;
            end
        end
        chk("period_match", mcnt, 64);
        chk("period_done_cnt", pcnt, 2);
        chk("period_errc", err_count, 0);
        chk("cycle_changes", chg, 8);
        chk("cycle_order", badchg, 0);

        // Single glitch: 0x10 replaced by 0x18
        step(1, 0, 8'h00);
        step(0, 1, 8'h80);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);
        step(0, 1, 8'h20);
        step(0, 1, 8'h18);
        chk("glitch_err", {locked, error, match, err_count}, {1'b1, 1'b1, 1'b0, 8'd1});
        step(0, 1, 8'h08);
        chk("glitch_recover", {locked, error, match, err_count}, {1'b1, 1'b0, 1'b1, 8'd1});

        // Loss of lock then reacquire on 0x01,0x01
        step(0, 1, 8'h00);
        chk("loss1", {locked, error}, {1'b1, 1'b1});
        step(0, 1, 8'h00);
        chk("loss2", {locked, error, err_count}, {1'b0, 1'b1, 8'd3});
        step(0, 1, 8'h01);
        step(0, 1, 8'h01);
        chk("reacq01", {locked, cycle, direction}, {1'b1, 2'd2, 1'b1});

        // Saturation on the 2-bit counter
        step(1, 0, 8'h00);
        for (int r = 0; r < 3; r++) begin
            step(0, 1, 8'h80);
            step(0, 1, 8'h80);
            step(0, 1, 8'h00);
            if (r < 2) step(0, 1, 8'h00);
        end
        chk("sat_ew8", err_count, 5);
        chk("sat_ew2", err_count2, 3);

        // Clear beats a valid sample
        step(1, 1, 8'h80);
        chk("clr_valid",
            {14'd0, locked, position, direction, cycle, match, error, err_count, period_done},
            32'd0);
        chk("clr_ec2", err_count2, 0);
        step(0, 1, 8'h80);
        chk("clr_ignored", locked, 1'b0);

        // Randomized traffic
        step(1, 0, 8'h00);
        gp = $urandom % 32;
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic v;
            logic [7:0] p;
            v = ($urandom % 5) != 0;
            r = $urandom % 100;
            if (r < 85) p = gen[gp];
            else if (r < 92) p = 8'($urandom);
            else if (r < 96) p = 8'h00;
            else begin
                gp = $urandom % 32;
                p = gen[gp];
            end
            if (v) gp = (gp + 1) % 32;
            step(($urandom % 500) == 0, v, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_checker.md
Name: pattern_checker

Overview:
- Receive-side monitor for the 8-bit bouncing one-hot pattern that the shifter/register/setFunc datapath generates.
- Samples the pattern bus on a strobe and acquires the phase of the sequence, then tracks it.
- Reports position, direction and sweep cycle, and flags and counts every deviation.
- Sits on the LED/pattern bus next to the generator for self-test.

Parameters:
- MISS_LIMIT, 2: number of consecutive mismatches in LOCKED that returns the block to HUNT.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous active-high reset.
- sample_valid  input  1  strobe; pattern is sampled only in cycles where this is 1.
- pattern  input  8  observed pattern bus.
- locked  output  1  phase acquired; tracking is active.
- position  output  3  index of the set bit in the last accepted sample (0 = LSB).
- direction  output  1  0 = right sweep (cycles 0,1); 1 = left sweep (cycles 2,3).
- cycle  output  2  tracked sweep cycle, 0..3.
- match  output  1  one-clock pulse: sample equalled the expected value while LOCKED.
- error  output  1  one-clock pulse: sample mismatched while LOCKED.
- err_count  output  ERR_W  saturating count of error pulses.
- period_done  output  1  one-clock pulse when the expected sequence wraps from cycle 3 to cycle 0.

Behaviour:
- Reference sequence model, function next(d,c):
  - Cycles 0,1 shift right. Cycles 2,3 shift left.
  - Right shift with d[0]=1: the next value is 0x01 if c=1, else 0x80; c increments.
  - Left shift with d[7]=1: the next value is 0x80 if c=3, else 0x01; c increments (3 wraps to 0).
  - Otherwise d shifts by one and c holds.
  - The period is 32 samples: 0x80..0x01, 0x80..0x01, 0x01..0x80, 0x01..0x80.
- Reset: when clear=1 at a clock edge, state becomes HUNT and every output and internal register goes to 0. clear overrides sample_valid in the same cycle.
- Timing:
  - All outputs are registered and update on the edge that accepts a sample (latency 1 clock).
  - Pulses last exactly one clock.
  - When sample_valid=0, state holds and all pulses are 0.
- FSM states: HUNT, LOCKED.
- HUNT:
  - Keep the last accepted sample in prev.
  - A sample equal to prev, where both are 0x01, means the block is entering cycle 2. Lock with cycle=2 and expected=next(0x01,2)=0x02.
  - A sample equal to prev, where both are 0x80, means the block is entering cycle 0. Lock with cycle=0 and expected=0x40.
  - Any other sample, including a non-one-hot value, only updates prev.
  - match, error and err_count are inactive in HUNT.
  - position and direction update only for one-hot samples.
- LOCKED, sample equal to expected:
  - match=1; expected and cycle advance by next(); miss counter clears.
  - position and direction are updated.
  - period_done=1 when cycle advances from 3 to 0.
- LOCKED, sample not equal to expected (includes zero and multi-hot values):
  - error=1; err_count increments and saturates at 2^ERR_W-1; miss counter increments.
  - expected and cycle still advance (flywheel), so a single glitch does not lose phase.
  - When the miss counter reaches MISS_LIMIT, the next state is HUNT, locked=0, the miss counter clears and prev is loaded with this sample.
- err_count clears only on clear; it is retained across HUNT and LOCKED.
- locked=1 from the edge that accepts the acquiring repeated sample.

Test Plan:
- Reset/idle: assert clear for 2 clocks, then sample_valid=0 for 10 clocks. All outputs stay 0 and the state stays HUNT.
- Acquire on 0x80,0x80: on the second sample, locked=1, cycle=0, direction=0. Then feed 0x40..0x01: 7 match pulses, no error.
- Full period: lock, then feed 64 generator samples. Required: 64 match pulses, exactly 2 period_done pulses, err_count=0, cycle sequence 0,1,2,3.
- Single glitch: while locked, replace one expected 0x10 with 0x18. Required: one error pulse, err_count=1, locked stays 1, and the following sample (0x08) gives a match pulse.
- Loss of lock: send MISS_LIMIT=2 consecutive 0x00 samples. Required: 2 error pulses and locked=0 after the second. Then 0x01,0x01 re-acquires with cycle=2 and direction=1.
- Saturation and reset: with ERR_W=2, inject 5 errors and check err_count stops at 3. Assert clear in the same cycle as a valid sample: all outputs 0 and the sample is ignored.
